// File: rtl/nco_seq_pkg.sv
// Shared types and helpers for the multi-lane NCO drive sequencer.
package nco_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic push_base;
        logic push_peak;
        logic pull_base;
        logic pull_peak;
    } drive_t;

    localparam drive_t DRIVE_OFF = drive_t'(4'b0000);

    // (step + inc) mod steps for step < steps and inc <= steps.
    function automatic int unsigned step_mod(input int unsigned step,
                                             input int unsigned inc,
                                             input int unsigned steps);
        int unsigned sum;
        sum = step + inc;
        return (sum >= steps) ? (sum - steps) : sum;
    endfunction

endpackage

// File: rtl/seq_drive_decode.sv
// Sequencer step index to PA drive pattern: push half then pull half,
// base held across the half, peak on its interior steps only.
module seq_drive_decode
    import nco_seq_pkg::*;
#(
    parameter  int unsigned STEPS  = 6,
    localparam int unsigned STEP_W = $clog2(STEPS)
) (
    input  logic [STEP_W-1:0] step,
    output drive_t            drive_c
);

    localparam int unsigned HALF = STEPS / 2;

    always_comb begin
        drive_c = DRIVE_OFF;
        if (32'(step) < HALF) begin
            drive_c.push_base = 1'b1;
            drive_c.push_peak = (32'(step) != 32'd0) && (32'(step) != HALF - 1);
        end else begin
            drive_c.pull_base = 1'b1;
            drive_c.pull_peak = (32'(step) != HALF) && (32'(step) != STEPS - 1);
        end
    end

endmodule

// File: rtl/nco_multilane_seq.sv
// LANES-sample-per-clock NCO driving a modulo-STEPS push/pull sequencer,
// with handshaked tuning-word load committed phase-continuously at wrap.
module nco_multilane_seq
    import nco_seq_pkg::*;
#(
    parameter  int unsigned ACC_W  = 32,
    parameter  int unsigned LANES  = 2,
    parameter  int unsigned STEPS  = 6,
    parameter  int unsigned WRAP_W = 16,
    localparam int unsigned STEP_W = $clog2(STEPS)
) (
    input  logic                    clk100MHz,
    input  logic                    resetN,
    input  logic                    enable,
    input  logic [ACC_W-1:0]        tuneWord,
    input  logic                    tuneValid,
    output logic                    tuneReady,
    output logic [LANES*STEP_W-1:0] stepIdx,
    output logic [LANES*4-1:0]      drive,
    output logic                    running,
    output logic [WRAP_W-1:0]       wrapCount
);

    logic [1:0]              rst_sync;
    logic                    rst_n;

    state_e                  state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [ACC_W-1:0]        active_q, active_d;
    logic [ACC_W-1:0]        pending_q, pending_d;
    logic                    pending_valid_q, pending_valid_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic [WRAP_W-1:0]       wrap_count_d;
    logic [LANES*STEP_W-1:0] step_idx_d;
    logic [LANES*4-1:0]      drive_d;

    logic [ACC_W-1:0]        acc_adv_c;
    logic [STEP_W-1:0]       step_adv_c;
    logic [LANES-1:0]        carry_c;
    logic [STEP_W-1:0]       lane_step_c [LANES];
    drive_t                  lane_drive_c [LANES];
    int unsigned             ones_c;
    int unsigned             raw_c;
    logic                    wrap_c;
    logic                    active_zero_c;
    logic                    commit_c;

    // Reset asserts asynchronously, releases on the clock.
    always_ff @(posedge clk100MHz or negedge resetN) begin
        if (!resetN) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Per-lane carry: overflow of (acc + k*active) + active, tested without a wide add.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [ACC_W-1:0] base_c;
        assign base_c     = acc_q + ACC_W'(k) * active_q;
        assign carry_c[k] = (base_c > ~active_q);

        seq_drive_decode #(.STEPS(STEPS)) u_decode (
            .step    (lane_step_c[k]),
            .drive_c (lane_drive_c[k])
        );
    end

    assign acc_adv_c     = acc_q + ACC_W'(LANES) * active_q;
    assign active_zero_c = (active_q == '0);

    // Lane k sits on step plus the carries of the earlier lanes.
    always_comb begin
        ones_c = 0;
        for (int k = 0; k < LANES; k++) begin
            lane_step_c[k] = STEP_W'(step_mod(32'(step_q), ones_c, STEPS));
            ones_c         = ones_c + 32'(carry_c[k]);
        end
        raw_c      = 32'(step_q) + ones_c;
        wrap_c     = (state_q != IDLE) && (raw_c >= STEPS);
        step_adv_c = STEP_W'(step_mod(32'(step_q), ones_c, STEPS));
    end

    // Next state, datapath update, tuning handshake and registered output images.
    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        step_d          = step_q;
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        wrap_count_d    = wrapCount;
        step_idx_d      = '0;
        drive_d         = '0;
        commit_c        = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = RUN;
                    acc_d    = '0;
                    step_d   = '0;
                    commit_c = pending_valid_q;
                end
            end
            RUN: begin
                acc_d    = acc_adv_c;
                step_d   = step_adv_c;
                commit_c = pending_valid_q && (wrap_c || active_zero_c);
                if (!enable) state_d = DRAIN;
            end
            DRAIN: begin
                if (wrap_c || active_zero_c) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    step_d  = '0;
                end else begin
                    acc_d  = acc_adv_c;
                    step_d = step_adv_c;
                    if (enable) state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wrap_c) wrap_count_d = wrapCount + WRAP_W'(1);

        // Commit needs a pending word and accept needs an empty slot: never both.
        if (commit_c) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
        end else if (tuneValid && !pending_valid_q) begin
            pending_d       = tuneWord;
            pending_valid_d = 1'b1;
        end

        if (state_q != IDLE) begin
            for (int k = 0; k < LANES; k++) begin
                step_idx_d[k*STEP_W +: STEP_W] = lane_step_c[k];
                drive_d[k*4 +: 4]              = lane_drive_c[k];
            end
        end
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            acc_q           <= '0;
            step_q          <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            stepIdx         <= '0;
            drive           <= '0;
            wrapCount       <= '0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            step_q          <= step_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            stepIdx         <= step_idx_d;
            drive           <= drive_d;
            wrapCount       <= wrap_count_d;
        end
    end

    assign running   = (state_q != IDLE);
    assign tuneReady = ~pending_valid_q;

endmodule
